// File: rtl/wimax_pkg.sv
// Shared constants, state types and reference address helper for the QPSK deinterleaver.
package wimax_pkg;

  localparam int unsigned NCBPS = 192;
  localparam int unsigned D     = 16;
  localparam int unsigned ROWS  = NCBPS / D;
  localparam int unsigned AW    = $clog2(NCBPS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(D);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_t;

  // Original-order address k of the bit received at interleaved index j.
  function automatic logic [AW-1:0] deint_addr(input int unsigned j);
    return AW'(D * (j % ROWS) + j / ROWS);
  endfunction

endpackage

// File: rtl/wimax_deinterleaver_if.sv
// Serial in/out handshake bundle of the deinterleaver.
interface wimax_deinterleaver_if;

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;
  logic blk_done;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_last, blk_done
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_last, blk_done
  );

endinterface

// File: rtl/wimax_deint_bank.sv
// One NCBPS-bit storage bank: single-bit write port, combinational single-bit read port.
module wimax_deint_bank
  import wimax_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data_c
);

  logic [NCBPS-1:0] mem;

  // Scattered writes of the permuted input bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong block deinterleaver: permuted writes into one bank while the other drains in order.
module wimax_deinterleaver
  import wimax_pkg::*;
(
  input  logic                   clk_ref,
  input  logic                   rst,
  wimax_deinterleaver_if.slave   io
);

  bank_state_t   bank_st [2];
  bank_state_t   bank_nxt [2];
  rd_state_t     rd_state, rd_state_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [AW-1:0] rd_addr, rd_addr_nxt;
  logic [AW-1:0] wr_addr;
  logic          in_ready_q, in_ready_nxt;
  logic          out_valid_q, out_valid_nxt;
  logic          out_bit_q, out_bit_nxt;
  logic          out_last_q, out_last_nxt;
  logic          blk_done_q, blk_done_nxt;
  logic          accept;
  logic          last_wr;
  logic          rd_data;
  logic [1:0]    rd_data_b;

  assign accept  = io.in_valid && in_ready_q;
  assign last_wr = (row == RW'(ROWS - 1)) && (col == CW'(D - 1));
  // D is a power of two, so D*row is a shift.
  assign wr_addr = AW'({row, CW'(0)}) + AW'(col);
  assign rd_data = rd_data_b[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wimax_deint_bank u_bank (
      .clk       (clk_ref),
      .we        (accept && (wr_bank == 1'(b))),
      .wr_addr   (wr_addr),
      .wr_data   (io.in_bit),
      .rd_addr   (rd_addr),
      .rd_data_c (rd_data_b[b])
    );
  end

  // State and output registers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      rd_state    <= RD_IDLE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      row         <= '0;
      col         <= '0;
      rd_addr     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      bank_st[0]  <= bank_nxt[0];
      bank_st[1]  <= bank_nxt[1];
      rd_state    <= rd_state_nxt;
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      row         <= row_nxt;
      col         <= col_nxt;
      rd_addr     <= rd_addr_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      out_bit_q   <= out_bit_nxt;
      out_last_q  <= out_last_nxt;
      blk_done_q  <= blk_done_nxt;
    end
  end

  // Write-side counters, bank lifecycle and read-side drain FSM.
  always_comb begin
    bank_nxt      = bank_st;
    rd_state_nxt  = rd_state;
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    row_nxt       = row;
    col_nxt       = col;
    rd_addr_nxt   = rd_addr;
    out_valid_nxt = out_valid_q;
    out_bit_nxt   = out_bit_q;
    out_last_nxt  = out_last_q;
    blk_done_nxt  = 1'b0;

    if (accept) begin
      if (last_wr) begin
        bank_nxt[wr_bank] = FULL;
        wr_bank_nxt       = ~wr_bank;
        row_nxt           = '0;
        col_nxt           = '0;
      end else begin
        bank_nxt[wr_bank] = FILLING;
        if (row == RW'(ROWS - 1)) begin
          row_nxt = '0;
          col_nxt = CW'(col + CW'(1));
        end else begin
          row_nxt = RW'(row + RW'(1));
        end
      end
    end

    case (rd_state)
      RD_IDLE: begin
        if (bank_st[rd_bank] == FULL) begin
          bank_nxt[rd_bank] = DRAINING;
          out_valid_nxt     = 1'b1;
          out_bit_nxt       = rd_data;
          out_last_nxt      = 1'b0;
          rd_addr_nxt       = AW'(1);
          rd_state_nxt      = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (io.out_ready) begin
          if (out_last_q) begin
            bank_nxt[rd_bank] = EMPTY;
            out_valid_nxt     = 1'b0;
            out_last_nxt      = 1'b0;
            blk_done_nxt      = 1'b1;
            rd_bank_nxt       = ~rd_bank;
            rd_addr_nxt       = '0;
            rd_state_nxt      = RD_IDLE;
          end else begin
            out_bit_nxt  = rd_data;
            out_last_nxt = (rd_addr == AW'(NCBPS - 1));
            rd_addr_nxt  = AW'(rd_addr + AW'(1));
          end
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase

    // Registered ready reflects the bank state the next cycle will see.
    in_ready_nxt = (bank_nxt[wr_bank_nxt] == EMPTY) || (bank_nxt[wr_bank_nxt] == FILLING);
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_bit   = out_bit_q;
  assign io.out_last  = out_last_q;
  assign io.blk_done  = blk_done_q;

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Randomised self-checking bench for wimax_deinterleaver against a direct permutation model.
module tb_wimax_deinterleaver;
  import wimax_pkg::*;

  typedef logic [191:0] blk_t;

  logic clk_ref = 1'b0;
  logic rst;

  wimax_deinterleaver_if io ();

  wimax_deinterleaver dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .io      (io)
  );

  always #5 clk_ref = ~clk_ref;

  int   total = 0;
  int   bad   = 0;
  int   cyc;
  logic src_q [$];
  blk_t exp_blocks [$];
  blk_t got_blocks [$];
  int   last_in_cyc [$];
  int   first_valid_cyc [$];
  int   last_xfer_cyc [$];
  blk_t in_acc, out_acc;
  int   in_j, out_k, in_cnt;
  bit   in_en;
  int   out_mode;
  bit   prev_stall, prev_bit, prev_last_xfer, first_seen;
  int   last_err, done_err, stall_err, ready_drop;
  int   pkg_err;
  int   n;

  task automatic check(input string tag, input blk_t got, input blk_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Receive index j lands at original index k = 16*(j mod 12) + j/12; index 0 is the MSB.
  function automatic blk_t ref_deint(input blk_t v);
    blk_t o;
    int   k;
    o = '0;
    for (int j = 0; j < 192; j++) begin
      k = 16 * (j % 12) + j / 12;
      o[191 - k] = v[191 - j];
    end
    return o;
  endfunction

  function automatic blk_t onehot(input int k);
    blk_t o;
    o = '0;
    o[191 - k] = 1'b1;
    return o;
  endfunction

  function automatic blk_t rand_block();
    blk_t v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic blk_t got_at(input int i);
    return (i < got_blocks.size()) ? got_blocks[i] : ~onehot(0);
  endfunction

  function automatic int qget(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic push_block(input blk_t v);
    for (int j = 0; j < 192; j++) src_q.push_back(v[191 - j]);
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_blocks.delete();
    got_blocks.delete();
    last_in_cyc.delete();
    first_valid_cyc.delete();
    last_xfer_cyc.delete();
    in_acc = '0;
    out_acc = '0;
    in_j = 0;
    out_k = 0;
    in_cnt = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_bit = 1'b0;
    prev_last_xfer = 1'b0;
    first_seen = 1'b0;
    last_err = 0;
    done_err = 0;
    stall_err = 0;
    ready_drop = 0;
  endtask

  // Drive one cycle, update the model with the transfers that the coming edge performs.
  task automatic cycle();
    logic in_x, out_x;
    blk_t e;
    io.in_valid = in_en && (src_q.size() != 0);
    io.in_bit   = (src_q.size() != 0) ? src_q[0] : 1'b0;
    case (out_mode)
      0:       io.out_ready = 1'b0;
      1:       io.out_ready = 1'b1;
      default: io.out_ready = 1'($urandom_range(0, 1));
    endcase
    in_x  = io.in_valid && io.in_ready;
    out_x = io.out_valid && io.out_ready;
    if (prev_stall && (!io.out_valid || io.out_bit !== prev_bit)) stall_err++;
    if (io.blk_done !== prev_last_xfer) done_err++;
    if (io.out_valid && !first_seen) begin
      first_valid_cyc.push_back(cyc);
      first_seen = 1'b1;
    end
    if (in_cnt > 0 && in_cnt < 384 && !io.in_ready) ready_drop++;
    prev_stall     = io.out_valid && !io.out_ready;
    prev_bit       = io.out_bit;
    prev_last_xfer = 1'b0;
    if (in_x) begin
      in_acc[191 - in_j] = io.in_bit;
      void'(src_q.pop_front());
      in_cnt++;
      in_j++;
      if (in_j == 192) begin
        exp_blocks.push_back(ref_deint(in_acc));
        last_in_cyc.push_back(cyc);
        in_j = 0;
      end
    end
    if (out_x) begin
      out_acc[191 - out_k] = io.out_bit;
      if (io.out_last !== (out_k == 191)) last_err++;
      if (out_k == 191) begin
        got_blocks.push_back(out_acc);
        e = (exp_blocks.size() != 0) ? exp_blocks.pop_front() : ~out_acc;
        check("blk_data", out_acc, e);
        prev_last_xfer = 1'b1;
        first_seen = 1'b0;
        last_xfer_cyc.push_back(cyc);
        out_k = 0;
      end else begin
        out_k++;
      end
    end
    @(posedge clk_ref);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((src_q.size() != 0 || exp_blocks.size() != 0 || in_j != 0 || out_k != 0) && k < budget) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
    check({tag, "_timeout"}, 192'(k >= budget), 192'(0));
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_out_last"}, 192'(last_err), 192'(0));
    check({tag, "_blk_done"}, 192'(done_err), 192'(0));
    check({tag, "_stable"}, 192'(stall_err), 192'(0));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_bit = 1'b0;
    io.out_ready = 1'b0;
    repeat (cycles) begin
      @(posedge clk_ref);
      #1;
    end
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    in_en = 1'b0;
    out_mode = 0;
    clear_model();
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_bit = 1'b0;
    io.out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk_ref);
      #1;
    end
    check("reset_outs", 192'({io.in_ready, io.out_valid, io.out_bit, io.out_last, io.blk_done}), 192'(0));
    rst = 1'b0;

    pkg_err = 0;
    for (int unsigned j = 0; j < 192; j++)
      if (deint_addr(j) != 8'(16 * (j % 12) + j / 12)) pkg_err++;
    check("pkg_deint_addr", 192'(pkg_err), 192'(0));

    // One-hot blocks.
    in_en = 1'b1;
    out_mode = 1;
    push_block(onehot(12));
    push_block(onehot(1));
    push_block(onehot(191));
    drain("onehot", 3000);
    check("onehot_j12", got_at(0), onehot(1));
    check("onehot_j1", got_at(1), onehot(16));
    check("onehot_j191", got_at(2), onehot(191));

    // Known vector.
    push_block(192'h4b047dfa42f2a5d5f61c021a5851e9a309a24fd58086bd1e);
    drain("vector", 2000);
    check("vector_out", got_at(3), 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA);
    check_flags("vector");

    // Back-to-back blocks at full rate.
    do_reset(2);
    in_en = 1'b1;
    out_mode = 1;
    repeat (3) push_block(rand_block());
    drain("b2b", 3000);
    check("b2b_in_ready", 192'(ready_drop), 192'(0));
    check("b2b_latency", 192'(qget(first_valid_cyc, 0) - qget(last_in_cyc, 0)), 192'(2));
    check("b2b_bubble01", 192'(qget(first_valid_cyc, 1) - qget(last_xfer_cyc, 0) - 1), 192'(1));
    check("b2b_bubble12", 192'(qget(first_valid_cyc, 2) - qget(last_xfer_cyc, 1) - 1), 192'(1));
    check("b2b_blocks", 192'(got_blocks.size()), 192'(3));
    check_flags("b2b");

    // Backpressure: both banks fill, then random drain.
    do_reset(2);
    in_en = 1'b1;
    out_mode = 0;
    repeat (3) push_block(rand_block());
    n = 0;
    while (n < 1500 && !(in_cnt > 0 && !io.in_ready)) begin
      cycle();
      n++;
    end
    check("bp_stall_point", 192'(in_cnt), 192'(384));
    repeat (20) cycle();
    check("bp_hold", 192'(in_cnt), 192'(384));
    out_mode = 2;
    drain("bp", 6000);
    check("bp_blocks", 192'(got_blocks.size()), 192'(3));
    check_flags("bp");

    // Reset while block 1 fills and block 0 drains.
    do_reset(2);
    in_en = 1'b1;
    out_mode = 0;
    repeat (3) push_block(rand_block());
    n = 0;
    while (n < 1500 && in_cnt < 242) begin
      cycle();
      n++;
    end
    out_mode = 1;
    while (n < 1500 && in_cnt < 292) begin
      cycle();
      n++;
    end
    check("mid_in_cnt", 192'(in_cnt), 192'(292));
    check("mid_out_k", 192'(out_k), 192'(50));
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    @(posedge clk_ref);
    #1;
    check("mid_rst_outs", 192'({io.in_ready, io.out_valid, io.out_bit, io.out_last, io.blk_done}), 192'(0));
    rst = 1'b0;
    clear_model();
    @(posedge clk_ref);
    #1;
    check("mid_post", 192'({io.out_valid, io.in_ready}), 192'(2'b01));
    in_en = 1'b1;
    out_mode = 1;
    push_block(rand_block());
    drain("fresh", 2000);
    check("fresh_latency", 192'(qget(first_valid_cyc, 0) - qget(last_in_cyc, 0)), 192'(2));
    check("fresh_blocks", 192'(got_blocks.size()), 192'(1));
    check_flags("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
